// File: rtl/ssram_pkg.sv
// Shared widths and types for the SSRAM arbiter and its read-return pipeline.
package ssram_pkg;
  localparam int SSRAM_ADDR_W   = 20;
  localparam int SSRAM_DATA_W   = 32;
  localparam int SSRAM_READ_LAT = 2;

  // One master command as seen by the arbiter.
  typedef struct packed {
    logic                    we;
    logic [SSRAM_ADDR_W-1:0] addr;
    logic [SSRAM_DATA_W-1:0] wdata;
    logic [3:0]              be;
  } ssram_cmd_t;

  // Read tag carried alongside each in-flight read; id selects the master.
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;
endpackage

// File: rtl/ssram_rd_pipe.sv
// Read-tag shift register: one stage per cycle from grant to data capture.
// The tail tag marks the cycle in which ssram_dq_in holds that read's data.
module ssram_rd_pipe
  import ssram_pkg::*;
#(
  parameter int DEPTH = SSRAM_READ_LAT + 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output logic    busy,
  output rd_tag_t tail
);

  rd_tag_t [DEPTH-1:0] pipe_q, pipe_d;

  // Shift one stage per cycle; stage 0 takes this cycle's grant tag.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Reset flushes every in-flight tag so no stale rvalid can follow.
  always_ff @(posedge clk) begin
    if (reset) pipe_q <= '0;
    else       pipe_q <= pipe_d;
  end

  // Busy while any read is still on its way back.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy = busy | pipe_q[i].valid;
  end

  assign tail = pipe_q[DEPTH-1];

endmodule

// File: rtl/ssram_arbiter.sv
// Two-master round-robin arbiter and command sequencer for a pipelined SSRAM.
// Commands granted in cycle T appear on the pins in T+1; reads return to the
// issuing master in T+READ_LAT+2. Writes wait until no read is in flight.
module ssram_arbiter
  import ssram_pkg::*;
#(
  parameter int ADDR_W   = SSRAM_ADDR_W,
  parameter int DATA_W   = SSRAM_DATA_W,
  parameter int READ_LAT = SSRAM_READ_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_be,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_be,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ssram_adsc_n,
  output logic              ssram_we_n,
  output logic              ssram_oe_n,
  output logic [3:0]        ssram_be_n,
  output logic [ADDR_W-1:0] ssram_addr,
  output logic [DATA_W-1:0] ssram_dq_out,
  output logic              ssram_dq_oe,
  input  logic [DATA_W-1:0] ssram_dq_in
);

  localparam int NUM_M = 2;

  ssram_cmd_t [NUM_M-1:0] cmd;
  ssram_cmd_t             sel;
  logic [NUM_M-1:0]       req, elig, gnt;
  logic                   prio_q, prio_d, oth, gnt_id, any_gnt, rd_busy;
  rd_tag_t                tag_in, tail;

  logic              adsc_n_q, adsc_n_d, we_n_q, we_n_d, dq_oe_q, dq_oe_d;
  logic [3:0]        be_n_q, be_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_out_q, dq_out_d;

  logic [NUM_M-1:0]             rvalid_q, rvalid_d;
  logic [NUM_M-1:0][DATA_W-1:0] rdata_q, rdata_d;

  assign req    = {m1_req, m0_req};
  assign cmd[0] = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, be: m0_be};
  assign cmd[1] = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, be: m1_be};

  // Round-robin pick; a blocked priority write stalls the other master so
  // a stream of reads cannot starve it.
  always_comb begin
    gnt = '0;
    oth = ~prio_q;
    for (int i = 0; i < NUM_M; i++) elig[i] = req[i] && !(cmd[i].we && rd_busy);
    if (!reset) begin
      if (elig[prio_q])                  gnt[prio_q] = 1'b1;
      else if (!req[prio_q] && elig[oth]) gnt[oth]    = 1'b1;
    end
    any_gnt = |gnt;
    gnt_id  = gnt[1];
    sel     = cmd[gnt_id];
    prio_d  = any_gnt ? ~gnt_id : prio_q;
    tag_in  = '{valid: any_gnt && !sel.we, id: gnt_id};
  end

  ssram_rd_pipe #(.DEPTH(READ_LAT + 1)) u_rd_pipe (
    .clk    (clk),
    .reset  (reset),
    .tag_in (tag_in),
    .busy   (rd_busy),
    .tail   (tail)
  );

  // Next pin state: a granted command for one cycle, otherwise idle with
  // address, data and byte enables held.
  always_comb begin
    adsc_n_d = ~any_gnt;
    we_n_d   = 1'b1;
    dq_oe_d  = 1'b0;
    be_n_d   = be_n_q;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    if (any_gnt) begin
      addr_d = sel.addr;
      if (sel.we) begin
        we_n_d   = 1'b0;
        be_n_d   = ~sel.be;
        dq_out_d = sel.wdata;
        dq_oe_d  = 1'b1;
      end else begin
        be_n_d = 4'h0;
      end
    end
  end

  // Capture returning read data for the master named by the tail tag.
  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (tail.valid) begin
      rvalid_d[tail.id] = 1'b1;
      rdata_d[tail.id]  = ssram_dq_in;
    end
  end

  // Pin, priority and return registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      adsc_n_q <= 1'b1;
      we_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      be_n_q   <= 4'hF;
      addr_q   <= '0;
      dq_out_q <= '0;
      prio_q   <= 1'b0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      adsc_n_q <= adsc_n_d;
      we_n_q   <= we_n_d;
      dq_oe_q  <= dq_oe_d;
      be_n_q   <= be_n_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      prio_q   <= prio_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign m0_gnt       = gnt[0];
  assign m1_gnt       = gnt[1];
  assign m0_rvalid    = rvalid_q[0];
  assign m1_rvalid    = rvalid_q[1];
  assign m0_rdata     = rdata_q[0];
  assign m1_rdata     = rdata_q[1];
  assign ssram_adsc_n = adsc_n_q;
  assign ssram_we_n   = we_n_q;
  assign ssram_oe_n   = ~rd_busy;
  assign ssram_be_n   = be_n_q;
  assign ssram_addr   = addr_q;
  assign ssram_dq_out = dq_out_q;
  assign ssram_dq_oe  = dq_oe_q;

endmodule

// File: tb/tb_ssram_arbiter.sv
// Bench for ssram_arbiter: SSRAM pin model plus a cycle-level reference of the
// arbitration rules, a golden memory and a queue of expected read returns.
module tb_ssram_arbiter;
  import ssram_pkg::*;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int RL = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic [3:0]    m0_be = '0, m1_be = '0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ssram_adsc_n, ssram_we_n, ssram_oe_n, ssram_dq_oe;
  logic [3:0]    ssram_be_n;
  logic [AW-1:0] ssram_addr;
  logic [DW-1:0] ssram_dq_out, ssram_dq_in = '0;

  always #5 clk = ~clk;

  ssram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ssram_adsc_n(ssram_adsc_n), .ssram_we_n(ssram_we_n), .ssram_oe_n(ssram_oe_n),
    .ssram_be_n(ssram_be_n), .ssram_addr(ssram_addr), .ssram_dq_out(ssram_dq_out),
    .ssram_dq_oe(ssram_dq_oe), .ssram_dq_in(ssram_dq_in)
  );

  function automatic logic [31:0] init_val(input int a);
    return 32'h5A5A_0000 ^ (32'(a) * 32'h0100_0193);
  endfunction

  // ---------------- SSRAM device model (pins sampled mid-cycle) -----------
  typedef struct { bit v; int a; } rd_t;
  rd_t hist [3];
  logic [31:0] smem [int];

  always @(negedge clk) begin
    logic [31:0] w;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0].v = (ssram_adsc_n === 1'b0) && (ssram_we_n === 1'b1);
    hist[0].a = int'(ssram_addr);
    // data for a read presented RL cycles after its address cycle
    if (hist[2].v) ssram_dq_in = smem.exists(hist[2].a) ? smem[hist[2].a] : init_val(hist[2].a);
    else           ssram_dq_in = $urandom;
    if (ssram_adsc_n === 1'b0 && ssram_we_n === 1'b0) begin
      w = smem.exists(int'(ssram_addr)) ? smem[int'(ssram_addr)] : init_val(int'(ssram_addr));
      for (int b = 0; b < 4; b++) if (!ssram_be_n[b]) w[8*b +: 8] = ssram_dq_out[8*b +: 8];
      smem[int'(ssram_addr)] = w;
    end
  end

  // ---------------- reference model state ---------------------------------
  typedef struct { int due; bit id; logic [31:0] data; } ret_t;
  ret_t retq[$];
  logic [31:0] gmem [int];
  int cyc = 0, last_rd = -1000;
  bit prio = 0, pins_known = 0;
  logic          e_adsc_n = 1, e_we_n = 1, e_dq_oe = 0;
  logic [3:0]    e_be_n = 4'hF;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_dq_out = '0;
  logic [DW-1:0] e_rdata [2];
  bit [1:0] obs_g;
  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [31:0] gread(input int a);
    return gmem.exists(a) ? gmem[a] : init_val(a);
  endfunction

  task automatic setm(input int m, input bit rq, input bit we, input int a,
                      input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin m0_req = rq; m0_we = we; m0_addr = AW'(a); m0_wdata = d; m0_be = be; end
    else        begin m1_req = rq; m1_we = we; m1_addr = AW'(a); m1_wdata = d; m1_be = be; end
  endtask

  // Check one cycle against the rules, then advance the model and the clock.
  task automatic tick();
    bit busy, gid, we;
    bit [1:0] rq, el, eg, ev;
    int a;
    logic [31:0] w, d;
    logic [3:0] be;
    @(negedge clk);
    busy = (cyc - last_rd) <= RL + 1;
    rq = {m1_req, m0_req};
    el[0] = m0_req && !(m0_we && busy);
    el[1] = m1_req && !(m1_we && busy);
    eg = '0;
    if (!reset) begin
      if (el[prio])                   eg[prio]  = 1'b1;
      else if (!rq[prio] && el[!prio]) eg[!prio] = 1'b1;
    end
    obs_g = {m1_gnt, m0_gnt};
    chk("gnt", obs_g, eg);
    if (pins_known) begin
      chk("adsc_n", ssram_adsc_n, e_adsc_n);
      chk("we_n",   ssram_we_n,   e_we_n);
      chk("dq_oe",  ssram_dq_oe,  e_dq_oe);
      chk("addr",   ssram_addr,   e_addr);
      chk("dq_out", ssram_dq_out, e_dq_out);
      chk("oe_n",   ssram_oe_n,   !busy);
      if (!e_adsc_n) chk("be_n", ssram_be_n, e_be_n);
      ev = '0;
      if (retq.size() > 0 && retq[0].due == cyc) begin
        ev[retq[0].id] = 1'b1;
        e_rdata[retq[0].id] = retq[0].data;
        void'(retq.pop_front());
      end
      chk("rvalid",   {m1_rvalid, m0_rvalid}, ev);
      chk("m0_rdata", m0_rdata, e_rdata[0]);
      chk("m1_rdata", m1_rdata, e_rdata[1]);
    end
    if (reset) begin
      e_adsc_n = 1; e_we_n = 1; e_dq_oe = 0; e_be_n = 4'hF; e_addr = '0; e_dq_out = '0;
      e_rdata[0] = '0; e_rdata[1] = '0;
      retq.delete(); prio = 0; last_rd = -1000; pins_known = 1;
    end else if (eg != 2'b00) begin
      gid = eg[1];
      we  = gid ? m1_we : m0_we;
      a   = int'(gid ? m1_addr : m0_addr);
      d   = gid ? m1_wdata : m0_wdata;
      be  = gid ? m1_be : m0_be;
      e_adsc_n = 0; e_addr = AW'(a);
      if (we) begin
        e_we_n = 0; e_be_n = ~be; e_dq_out = d; e_dq_oe = 1;
        w = gread(a);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        gmem[a] = w;
      end else begin
        e_we_n = 1; e_be_n = 4'h0; e_dq_oe = 0;
        retq.push_back('{due: cyc + RL + 2, id: gid, data: gread(a)});
        last_rd = cyc;
      end
      prio = !gid;
    end else begin
      e_adsc_n = 1; e_we_n = 1; e_dq_oe = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    setm(0, 0, 0, 0, 0, 0);
    setm(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    bit [1:0] prev;
    e_rdata[0] = '0; e_rdata[1] = '0;
    reset = 1; tick(); tick(); reset = 0;
    chk("rst_adsc_n", ssram_adsc_n, 1'b1);
    chk("rst_be_n",   ssram_be_n,   4'hF);
    chk("rst_oe_n",   ssram_oe_n,   1'b1);
    idle(1);

    // single write then read from m0
    setm(0, 1, 1, 'h10, 32'hDEADBEEF, 4'hF); tick();
    chk("t1_wr_gnt", obs_g, 2'b01);
    chk("t1_we_n", ssram_we_n, 1'b0);
    setm(0, 1, 0, 'h10, 0, 0); tick();
    chk("t1_rd_gnt", obs_g, 2'b01);
    chk("t1_rd_adsc", ssram_adsc_n, 1'b0);
    idle(3);
    chk("t1_rvalid", m0_rvalid, 1'b1);
    chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
    idle(2);

    // both masters streaming reads: strict alternation
    setm(0, 1, 0, 'h100, 0, 0); setm(1, 1, 0, 'h200, 0, 0);
    tick(); prev = obs_g;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_alt", obs_g, prev ^ 2'b11);
      prev = obs_g;
    end
    idle(6);

    // m1 reads alone, then m0 write under rd_busy stalls both for RL+1 cycles
    setm(1, 1, 0, 'h300, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    setm(0, 1, 1, 'h30, 32'hCAFEF00D, 4'hF);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_g[0]) break;
      n++;
    end
    chk("t3_stall", n, RL + 1);
    setm(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    idle(6);

    // byte-enable merge
    setm(0, 1, 1, 'h40, 32'hAABBCCDD, 4'hF); tick();
    setm(0, 1, 1, 'h40, 32'h11223344, 4'b0101); tick();
    chk("t4_be_n", ssram_be_n, 4'b1010);
    setm(0, 1, 0, 'h40, 0, 0); tick();
    idle(3);
    chk("t4_rvalid", m0_rvalid, 1'b1);
    chk("t4_rdata", m0_rdata, 32'hAA22CC44);
    idle(2);

    // reset with two reads in flight
    setm(0, 1, 0, 'h100, 0, 0); setm(1, 1, 0, 'h200, 0, 0);
    tick(); tick();
    setm(0, 0, 0, 0, 0, 0); setm(1, 0, 0, 0, 0, 0);
    reset = 1; tick(); reset = 0;
    chk("t5_adsc_n", ssram_adsc_n, 1'b1);
    chk("t5_we_n",   ssram_we_n,   1'b1);
    chk("t5_oe_n",   ssram_oe_n,   1'b1);
    chk("t5_be_n",   ssram_be_n,   4'hF);
    chk("t5_addr",   ssram_addr,   '0);
    chk("t5_dq_oe",  ssram_dq_oe,  1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
    end
    setm(0, 1, 0, 'h100, 0, 0); setm(1, 1, 0, 'h200, 0, 0);
    tick();
    chk("t5_prio_m0", obs_g, 2'b01);
    idle(6);

    // only m1 requesting: granted every cycle
    setm(1, 1, 0, 'h250, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_m1_gnt", obs_g, 2'b10);
    end
    idle(6);

    // randomized traffic, protocol-legal (hold until granted, rare drops)
    for (int k = 0; k < 600; k++) begin
      for (int m = 0; m < 2; m++) begin
        bit cur = (m == 0) ? m0_req : m1_req;
        if (!cur || obs_g[m]) begin
          if ($urandom_range(0, 3) != 0)
            setm(m, 1, $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom,
                 4'($urandom_range(1, 15)));
          else setm(m, 0, 0, 0, 0, 0);
        end else if ($urandom_range(0, 15) == 0) begin
          setm(m, 0, 0, 0, 0, 0);
        end
      end
      tick();
    end
    idle(8);
    chk("final_retq_empty", retq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssram_arbiter.md
Name: ssram_arbiter

Overview:
- Two-requester arbiter and command sequencer for the board's 32-bit pipelined synchronous SSRAM (ADSC-started, single-word accesses).
- Sits between two on-chip masters (e.g. video writer, video reader) and the SSRAM pins; the top level ties the split dq bus to the FS_DQ tristate.
- Round-robin grant, one command per cycle, tagged read-return pipeline, automatic read-to-write bus turnaround.

Parameters:
- ADDR_W, 20, word address width (drives FS_ADDR[21:2]).
- DATA_W, 32, data width.
- READ_LAT, 2, SSRAM cycles from the pin address edge to valid read data.

Ports:
- clk  in  1  system clock; the SSRAM clock shares this clock.
- reset  in  1  synchronous, active-high reset.
- m0_req, m1_req  in  1  access request, held until granted.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  ADDR_W  word address.
- m0_wdata, m1_wdata  in  DATA_W  write data.
- m0_be, m1_be  in  4  byte enables, active high.
- m0_gnt, m1_gnt  out  1  combinational; the request is accepted this cycle.
- m0_rvalid, m1_rvalid  out  1  read data valid, one-cycle pulse.
- m0_rdata, m1_rdata  out  DATA_W  read data.
- ssram_adsc_n  out  1  begin-transfer strobe.
- ssram_we_n  out  1  write strobe.
- ssram_oe_n  out  1  output enable.
- ssram_be_n  out  4  byte enables, active low.
- ssram_addr  out  ADDR_W  address.
- ssram_dq_out  out  DATA_W  write data.
- ssram_dq_oe  out  1  FPGA drives dq.
- ssram_dq_in  in  DATA_W  sampled dq.

Behaviour:
- Reset values:
  - adsc_n, we_n, oe_n = 1; be_n = 4'hF; addr, dq_out = 0; dq_oe = 0.
  - gnt = 0; rvalid = 0; rdata = 0.
  - Priority pointer = m0; read pipeline empty.
- Command timing:
  - A grant in cycle T registers the command onto the pins during cycle T+1.
  - adsc_n = 0 for exactly that cycle.
  - Writes: we_n = 0, be_n = ~be, dq_out = wdata, dq_oe = 1 in T+1.
  - Reads: we_n = 1, be_n = 4'h0, dq_oe = 0.
  - With no grant in T, cycle T+1 is idle: adsc_n = 1, we_n = 1, dq_oe = 0, addr/dq_out hold.
- Read return:
  - Tag pipeline of depth READ_LAT+1 carries (valid, id) for every read grant.
  - ssram_dq_in is captured at the end of cycle T+1+READ_LAT.
  - rvalid and rdata are presented to the issuing master in cycle T+READ_LAT+2 (cycle T+4 by default).
  - The other master's rvalid stays 0.
  - rdata holds its last value between pulses.
- ssram_oe_n = 0 in every cycle in which any read tag is in flight; 1 otherwise.
- Turnaround:
  - rd_busy = a read was granted in any of the last READ_LAT+1 cycles.
  - A write cannot be granted while rd_busy; this yields at least one idle pin cycle between the last read data and write drive.
  - Write followed by read needs no gap.
- Arbitration, evaluated each cycle. "Eligible" means req && !(we && rd_busy).
  - Priority master eligible: grant it.
  - Else, priority master not requesting and other master eligible: grant the other.
  - Else, priority master requesting but blocked (a write under rd_busy): grant nothing. This stall prevents read streams from starving writes.
  - After any grant, priority moves to the non-granted master; it is unchanged on idle cycles.
- gnt is asserted to at most one master per cycle.
- Throughput: back-to-back reads or back-to-back writes at 1 per cycle. Read-to-write costs READ_LAT+1 stall cycles.
- Simultaneous req:
  - Both reads or both writes: alternate grants m0, m1, m0, ...
- Reset mid-operation:
  - The pipeline is flushed; no rvalid is issued for in-flight reads.
  - Pins return to reset values on the next cycle.
- Masters must hold req and all fields stable until gnt; a request dropped before gnt is legal and discarded.

Decomposition:
- Package ssram_pkg: ADDR_W, DATA_W, READ_LAT defaults; typedef ssram_cmd_t {we, addr, wdata, be}; typedef rd_tag_t {valid, id}.
- Sub-module ssram_rd_pipe: parameterised shift register of rd_tag_t. Outputs busy (any valid) and the tail tag that drives return demux and capture.
- Arbiter and pin registers live in ssram_arbiter.

Test Plan:
- Single write, then read, from m0: write addr 0x00010 data 0xDEADBEEF be 4'hF at T=0; read granted at T=1.
  - Required: pins show we_n = 0 at cycle 1, adsc_n = 0 at cycles 1 and 2.
  - Required: m0_rvalid at cycle 5 with rdata 0xDEADBEEF (SSRAM model).
- Both masters hold continuous reads, addr 0x100 / 0x200:
  - Required: grants alternate m0, m1 each cycle, adsc_n low every cycle.
  - Required: rvalid returns alternate with the correct id and a 4-cycle latency.
- m1 streaming reads while m0 raises a write at cycle 10 (priority = m0 at cycle 10):
  - Required: no grants in cycles 10–12.
  - Required: m0 write granted at cycle 13; dq_oe never high while oe_n = 0.
- Byte-enable write: be 4'b0101, data 0x11223344 over a word holding 0xAABBCCDD.
  - Required: ssram_be_n = 4'b1010; readback = 0xAA22CC44.
- reset asserted one cycle after two reads are granted:
  - Required: no rvalid afterwards; all pins at reset values the next cycle; priority = m0.
- Only m1 requesting while priority = m0:
  - Required: m1 granted every cycle; priority toggles back to m0 after each grant.
